// File: rtl/iir_inverse_fir_folded.sv
// Folded 2nd-order inverse FIR: x[n] = y[n] - h1*y[n-1] - h2*y[n-2].
// One multiplier and one subtractor are time-shared across two phases per sample.
module iir_inverse_fir_folded #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [N-1:0] h1,
    input  logic [N-1:0] h2,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y_in,
    output logic         out_valid,
    output logic [N-1:0] x_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PH1  = 2'd1,
        S_PH2  = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_y;
    logic [N-1:0] r_c1;
    logic [N-1:0] r_c2;
    logic [N-1:0] r_d1;
    logic [N-1:0] r_d2;
    logic [N-1:0] r_acc;
    logic [N-1:0] r_x;
    logic         r_out_valid;

    logic         w_accept;
    logic         w_is_ph1;
    logic [N-1:0] w_mul_a;
    logic [N-1:0] w_mul_b;
    logic [N-1:0] w_prod_lo;
    logic [N-1:0] w_minuend;
    logic [N-1:0] w_diff;

    assign w_is_ph1 = (r_state == S_PH1);
    assign in_ready = !w_is_ph1 && !clr;
    assign w_accept = in_valid && in_ready;

    // Shared datapath: PH1 forms y - c1*d1, PH2 forms acc - c2*d2.
    assign w_mul_a   = w_is_ph1 ? r_c1 : r_c2;
    assign w_mul_b   = w_is_ph1 ? r_d1 : r_d2;
    assign w_minuend = w_is_ph1 ? r_y  : r_acc;

    // Only the N LSBs of the signed 2N product are kept; those bits are identical
    // for signed and unsigned operands, so an N-bit multiply is bit-exact.
    assign w_prod_lo = w_mul_a * w_mul_b;
    assign w_diff    = w_minuend - w_prod_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_c1        <= '0;
            r_c2        <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= S_IDLE;
            r_d1        <= '0;
            r_d2        <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_y     <= y_in;
                        r_c1    <= h1;
                        r_c2    <= h2;
                        r_state <= S_PH1;
                    end
                end
                S_PH1: begin
                    r_acc   <= w_diff;
                    r_state <= S_PH2;
                end
                S_PH2: begin
                    r_x         <= w_diff;
                    r_out_valid <= 1'b1;
                    r_d2        <= r_d1;
                    r_d1        <= r_y;
                    if (w_accept) begin
                        r_y     <= y_in;
                        r_c1    <= h1;
                        r_c2    <= h2;
                        r_state <= S_PH1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign x_out     = r_x;

endmodule

// File: tb/tb_iir_inverse_fir_folded.sv
// Randomised self-checking bench for iir_inverse_fir_folded against a difference-equation model.
module tb_iir_inverse_fir_folded;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [15:0] h1;
    logic [15:0] h2;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic        out_valid;
    logic [15:0] x_out;

    iir_inverse_fir_folded #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .h1        (h1),
        .h2        (h2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .x_out     (x_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] m1    = '0;     // y[n-1] of completed samples
    logic [15:0] m2    = '0;     // y[n-2]
    logic [15:0] last_x = '0;
    logic [15:0] qv[$];
    int          qc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (qv.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                chk("x_out", {16'h0, x_out}, {16'h0, qv[0]});
                chk("latency", cyc, qc[0]);
                void'(qv.pop_front());
                void'(qc.pop_front());
            end
            last_x = x_out;
        end
    end

    function automatic logic [15:0] model(input logic [15:0] y, c1, c2, p1, p2);
        int e;
        e = int'($signed(y)) - int'($signed(c1)) * int'($signed(p1))
                             - int'($signed(c2)) * int'($signed(p2));
        return e[15:0];
    endfunction

    task automatic flush_model();
        qv.delete();
        qc.delete();
        m1 = '0;
        m2 = '0;
    endtask

    // Starts and ends at a negedge; ends in the PH1 cycle of the sample.
    task automatic send(input logic [15:0] y, c1, c2, input int gap);
        bit ok;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            @(negedge clk);
            chk("gap_in_ready", {31'h0, in_ready}, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        y_in = y;
        h1 = c1;
        h2 = c2;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        qv.push_back(model(y, c1, c2, m1, m2));
        qc.push_back(cyc + 2);
        m2 = m1;
        m1 = y;
        in_valid = 1'b0;
        y_in = 16'($urandom);
        h1 = 16'($urandom);
        h2 = 16'($urandom);
        @(negedge clk);
        chk("ph1_in_ready", {31'h0, in_ready}, 0);
    endtask

    task automatic do_clr(input bit offer);
        clr = 1'b1;
        in_valid = offer;
        y_in = 16'($urandom);
        #1;
        chk("clr_in_ready", {31'h0, in_ready}, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        flush_model();
        chk("clr_keeps_x", {16'h0, x_out}, {16'h0, last_x});
        chk("clr_out_valid", {31'h0, out_valid}, 0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
        h1 = '0; h2 = '0; y_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_in_ready", {31'h0, in_ready}, 1);
            chk("rst_out_valid", {31'h0, out_valid}, 0);
            chk("rst_x_out", {16'h0, x_out}, 0);
        end

        // Impulse response of the IIR, back to back
        send(16'd1, 16'd2, 16'd4, 0);
        send(16'd2, 16'd2, 16'd4, 0);
        send(16'd8, 16'd2, 16'd4, 0);
        send(16'd24, 16'd2, 16'd4, 0);
        idle(4);
        chk("impulse_last", {16'h0, last_x}, 0);

        // Wrap / sign: third output must be -4
        do_clr(0);
        send(16'd1, 16'd2, 16'd4, 0);
        send(16'd2, 16'd2, 16'd4, 0);
        send(16'd4, 16'd2, 16'd4, 0);
        idle(4);
        chk("wrap_last", {16'h0, last_x}, 32'h0000_FFFC);

        // Coefficient change while the previous sample is in flight
        do_clr(0);
        send(16'd1, 16'd2, 16'd4, 0);
        send(16'd2, 16'd3, 16'd4, 0);
        idle(4);
        chk("coef_change_last", {16'h0, last_x}, 32'h0000_FFFF);

        // clr drops the in-flight sample; clr also blocks an offer while idle
        do_clr(0);
        send(16'd5, 16'd2, 16'd4, 0);
        do_clr(0);
        send(16'd7, 16'd2, 16'd4, 0);
        idle(4);
        chk("clr_next_last", {16'h0, last_x}, 32'h0000_0007);
        do_clr(1);
        idle(4);

        // Sparse input, gaps of three idle cycles
        send(16'd1, 16'd2, 16'd4, 3);
        send(16'd2, 16'd2, 16'd4, 3);
        send(16'd8, 16'd2, 16'd4, 3);
        send(16'd24, 16'd2, 16'd4, 3);
        idle(4);
        chk("sparse_last", {16'h0, last_x}, 0);

        // Reset mid-sample clears x_out as well
        send(16'd9, 16'd1, 16'd1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush_model();
        last_x = '0;
        chk("midrst_x_out", {16'h0, x_out}, 0);
        chk("midrst_out_valid", {31'h0, out_valid}, 0);
        chk("midrst_in_ready", {31'h0, in_ready}, 1);
        @(negedge clk);

        // Randomised traffic with occasional clr
        for (int i = 0; i < 300; i++) begin
            send(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) do_clr(1'($urandom));
        end
        idle(6);
        chk("drain_queue_empty", qv.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
